// File: rtl/register_ram_arbiter.sv
// Two-port req/ack arbiter and clear sequencer in front of a 1-cycle synchronous register RAM.
// Accesses are serialised as IDLE -> ISSUE -> RESP; a 2**ADDR_WIDTH-cycle clear sweep runs after reset.
module register_ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear_req,
    output logic                  busy,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out
);

    typedef enum logic [1:0] {StClear, StIdle, StIssue, StResp} state_e;

    localparam logic PortA = 1'b0;
    localparam logic PortB = 1'b1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  owner_q, owner_d;
    logic                  last_grant_q, last_grant_d;
    logic                  lat_we_q, lat_we_d;
    logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

    logic a_elig, b_elig, grant_b;

    // A port still showing its ack holds a stale req and must not be re-granted.
    assign a_elig  = a_req && !a_ack_q;
    assign b_elig  = b_req && !b_ack_q;
    assign grant_b = b_elig && (!a_elig || (last_grant_q == PortA));

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        lat_we_d     = lat_we_q;
        lat_addr_d   = lat_addr_q;
        lat_wdata_d  = lat_wdata_q;
        a_ack_d      = 1'b0;
        b_ack_d      = 1'b0;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) state_d = StIdle;
            end
            StIdle: begin
                if (clear_req) begin
                    state_d   = StClear;
                    clr_cnt_d = '0;
                end else if (a_elig || b_elig) begin
                    owner_d      = grant_b;
                    last_grant_d = grant_b;
                    lat_we_d     = grant_b ? b_we    : a_we;
                    lat_addr_d   = grant_b ? b_addr  : a_addr;
                    lat_wdata_d  = grant_b ? b_wdata : a_wdata;
                    state_d      = StIssue;
                end
            end
            StIssue: state_d = StResp;
            StResp: begin
                // RAM output holds the pre-write contents, so write acks return old data.
                if (owner_q == PortB) begin
                    b_rdata_d = ram_data_out;
                    b_ack_d   = 1'b1;
                end else begin
                    a_rdata_d = ram_data_out;
                    a_ack_d   = 1'b1;
                end
                state_d = StIdle;
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StClear;
            clr_cnt_q    <= '0;
            owner_q      <= PortA;
            last_grant_q <= PortB;
            lat_we_q     <= 1'b0;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            lat_we_q     <= lat_we_d;
            lat_addr_q   <= lat_addr_d;
            lat_wdata_q  <= lat_wdata_d;
            a_ack_q      <= a_ack_d;
            b_ack_q      <= b_ack_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    always_comb begin
        ram_write_en = 1'b0;
        ram_address  = lat_addr_q;
        ram_data_in  = lat_wdata_q;
        unique case (state_q)
            StClear: begin
                ram_write_en = 1'b1;
                ram_address  = clr_cnt_q;
                ram_data_in  = CLEAR_VALUE;
            end
            StIssue: ram_write_en = lat_we_q;
            default: ;
        endcase
        if (reset) ram_write_en = 1'b0;
    end

    assign busy    = (state_q == StClear);
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
